// File: rtl/ctr_obs_sync_pkg.sv
// Shared types and constants for the relational contract checker.
//   ctr_sync_state_e : checker FSM encoding (RUN, DRAIN, DONE)
//   CTR_OBS_W/CTR_DEPTH/CTR_CNT_W : default parameter values
//   CTR_IDX_NONE : mismatch index value meaning "no violation yet"
package ctr_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } ctr_sync_state_e;

  localparam int CTR_OBS_W = 128;
  localparam int CTR_DEPTH = 8;
  localparam int CTR_CNT_W = 16;

  localparam logic [CTR_CNT_W-1:0] CTR_IDX_NONE = '1;

endpackage

// File: rtl/ctr_obs_sync_if.sv
// Observation bus feeding the checker: both runs' retire strobes and
// records, the runtime comparison mask and the end-of-trace request.
//   master : observation builders / formal top (drive)
//   slave  : ctr_obs_sync (sample)
interface ctr_obs_sync_if
  import ctr_pkg::*;
#(
  parameter int OBS_W = CTR_OBS_W
);
  logic             retire_1_i;
  logic [OBS_W-1:0] obs_1_i;
  logic             retire_2_i;
  logic [OBS_W-1:0] obs_2_i;
  logic [OBS_W-1:0] obs_mask_i;
  logic             drain_i;

  modport master (
    output retire_1_i, obs_1_i, retire_2_i, obs_2_i, obs_mask_i, drain_i
  );

  modport slave (
    input retire_1_i, obs_1_i, retire_2_i, obs_2_i, obs_mask_i, drain_i
  );
endinterface

// File: rtl/ctr_obs_sync_fifo.sv
// Synchronous FIFO holding one run's pending observations.
//   clk_i, rst_i : clock, synchronous active-high reset (empties the queue)
//   push, data   : enqueue data; accepted when not full or when popping
//   pop          : dequeue head; ignored when empty
//   full, empty  : occupancy flags
//   head         : oldest record (valid when !empty)
module ctr_obs_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Extra MSB on each pointer is a wrap bit, distinguishing full from empty.
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= data;
  end
endmodule

// File: rtl/ctr_obs_sync.sv
// Relational contract checker for two lock-stepped runs of one core.
// Queues each run's retired observations, compares them pairwise in program
// order under a runtime mask, and keeps a sticky equivalence verdict.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   obs               : observation bus (slave modport)
//   ctr_equiv_o       : sticky verdict, 1 until any violation
//   mismatch_o        : one-cycle pulse per detected violation
//   mismatch_idx_o    : pair index of first violation (all-ones = none)
//   cmp_count_o       : pairs compared, saturating
//   overflow_o        : sticky, a queue dropped a record
//   done_o            : drain finished
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_RUN   | normal operation, waiting for drain request
// ST_DRAIN | finishing outstanding pairs, then checking queue occupancy
// ST_DONE  | verdict frozen; only reset leaves
module ctr_obs_sync
  import ctr_pkg::*;
#(
  parameter int OBS_W = CTR_OBS_W,
  parameter int DEPTH = CTR_DEPTH,
  parameter int CNT_W = CTR_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  ctr_obs_sync_if.slave    obs,
  output logic             ctr_equiv_o,
  output logic             mismatch_o,
  output logic [CNT_W-1:0] mismatch_idx_o,
  output logic [CNT_W-1:0] cmp_count_o,
  output logic             overflow_o,
  output logic             done_o
);
  localparam logic [CNT_W-1:0] IDX_NONE = '1;

  ctr_sync_state_e state, state_nxt;

  logic             live, cmp, diff, hit, diverge;
  logic             push_1, push_2, ovf_1, ovf_2;
  logic             full_1, full_2, empty_1, empty_2;
  logic [OBS_W-1:0] head_1, head_2;

  // Nothing enters the queues once the verdict is frozen.
  assign live   = (state != ST_DONE);
  assign push_1 = obs.retire_1_i && live;
  assign push_2 = obs.retire_2_i && live;
  assign cmp    = !empty_1 && !empty_2 && live;

  // A full queue only drops when it is not also popping this cycle.
  assign ovf_1  = push_1 && full_1 && !cmp;
  assign ovf_2  = push_2 && full_2 && !cmp;

  assign diff    = |((head_1 ^ head_2) & obs.obs_mask_i);
  assign hit     = cmp && diff;
  assign diverge = (state == ST_DRAIN) && !cmp && (!empty_1 || !empty_2);
  assign done_o  = (state == ST_DONE);

  ctr_obs_fifo #(.WIDTH(OBS_W), .DEPTH(DEPTH)) u_q1 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push_1),
    .data  (obs.obs_1_i),
    .pop   (cmp),
    .full  (full_1),
    .empty (empty_1),
    .head  (head_1)
  );

  ctr_obs_fifo #(.WIDTH(OBS_W), .DEPTH(DEPTH)) u_q2 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push_2),
    .data  (obs.obs_2_i),
    .pop   (cmp),
    .full  (full_2),
    .empty (empty_2),
    .head  (head_2)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (obs.drain_i) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!cmp)        state_nxt = ST_DONE;
      ST_DONE:                   state_nxt = ST_DONE;
      default:                   state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctr_equiv_o    <= 1'b1;
      mismatch_o     <= 1'b0;
      mismatch_idx_o <= IDX_NONE;
      cmp_count_o    <= '0;
      overflow_o     <= 1'b0;
    end else begin
      mismatch_o <= hit || ovf_1 || ovf_2 || diverge;
      if (hit || ovf_1 || ovf_2 || diverge) ctr_equiv_o <= 1'b0;
      if (ovf_1 || ovf_2) overflow_o <= 1'b1;
      // Index captures the count before this cycle's increment.
      if ((hit || diverge) && (mismatch_idx_o == IDX_NONE))
        mismatch_idx_o <= cmp_count_o;
      if (cmp && (cmp_count_o != IDX_NONE))
        cmp_count_o <= cmp_count_o + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_ctr_obs_sync.sv
module tb_ctr_obs_sync;
  import ctr_pkg::*;

  localparam int W  = 128;
  localparam int NV = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] m;
    logic         d;
  } vec_t;

  typedef struct {
    logic        equiv;
    logic        mis;
    logic [15:0] cnt;
    logic [15:0] idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        equiv, mis, ovf, done;
  logic [15:0] idx, cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int mis_pulses;

  vec_t         vt [NV];
  exp_t         sbq [$];
  exp_t         e;
  logic [W-1:0] all1, b100, v1, v2;
  logic         eq_m;
  logic [15:0]  cnt_m, idx_m;

  always #5 clk = ~clk;

  ctr_obs_sync_if #(.OBS_W(W)) obs_if ();

  ctr_obs_sync #(.OBS_W(W), .DEPTH(8), .CNT_W(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .obs            (obs_if),
    .ctr_equiv_o    (equiv),
    .mismatch_o     (mis),
    .mismatch_idx_o (idx),
    .cmp_count_o    (cnt),
    .overflow_o     (ovf),
    .done_o         (done)
  );

  always @(posedge clk) begin
    if (rst)      mis_pulses <= 0;
    else if (mis) mis_pulses <= mis_pulses + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r1, input logic [W-1:0] o1,
                       input logic r2, input logic [W-1:0] o2, input logic d);
    obs_if.retire_1_i = r1;
    obs_if.obs_1_i    = o1;
    obs_if.retire_2_i = r2;
    obs_if.obs_2_i    = o2;
    obs_if.drain_i    = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    obs_if.obs_mask_i = all1;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " equiv"},    32'(equiv), 32'd1);
    check({tag, " mismatch"}, 32'(mis),   32'd0);
    check({tag, " idx"},      32'(idx),   32'(CTR_IDX_NONE));
    check({tag, " count"},    32'(cnt),   32'd0);
    check({tag, " overflow"}, 32'(ovf),   32'd0);
    check({tag, " done"},     32'(done),  32'd0);
  endtask

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] m, input logic d);
    vec_t v;
    v.a = a; v.b = b; v.m = m; v.d = d;
    return v;
  endfunction

  initial begin
    all1 = '1;
    b100 = '0;
    b100[100] = 1'b1;
    // records run1, run2, mask in effect for that pair, expected diff
    vt[0] = mk(W'(1),   W'(1), all1,      1'b0);
    vt[1] = mk(W'(2),   W'(2), all1,      1'b0);
    vt[2] = mk(b100,    '0,    ~b100,     1'b0);
    vt[3] = mk(W'(3),   W'(3), all1,      1'b0);
    vt[4] = mk(b100,    '0,    all1,      1'b1);
    vt[5] = mk(W'(5),   W'(4), ~W'(1),    1'b0);
    vt[6] = mk(W'(5),   W'(4), all1,      1'b1);
    vt[7] = mk(W'(7),   W'(7), all1,      1'b0);

    obs_if.obs_mask_i = all1;
    rst = 1'b1;
    idle(1);

    // Reset state.
    do_reset();
    check_reset_vals("reset");

    // Identical records 1..5 on the same cycles, then drain.
    for (int i = 0; i < 5; i++) drive(1'b1, W'(i + 1), 1'b1, W'(i + 1), 1'b0);
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    check("equal drain_pending done", 32'(done), 32'd0);
    idle(1);
    check("equal done",     32'(done),  32'd1);
    check("equal equiv",    32'(equiv), 32'd1);
    check("equal count",    32'(cnt),   32'd5);
    check("equal idx",      32'(idx),   32'(CTR_IDX_NONE));
    check("equal pulses",   32'(mis_pulses), 32'd0);

    // Table-driven pairs with scoreboard; mask applies in the compare cycle.
    do_reset();
    eq_m = 1'b1; cnt_m = '0; idx_m = CTR_IDX_NONE;
    for (int s = 0; s < NV + 2; s++) begin
      if (s >= 2) begin
        e = sbq.pop_front();
        check($sformatf("tbl%0d equiv", s - 2), 32'(equiv), 32'(e.equiv));
        check($sformatf("tbl%0d mismatch", s - 2), 32'(mis), 32'(e.mis));
        check($sformatf("tbl%0d count", s - 2), 32'(cnt), 32'(e.cnt));
        check($sformatf("tbl%0d idx", s - 2), 32'(idx), 32'(e.idx));
      end
      if (s >= 1 && s <= NV) obs_if.obs_mask_i = vt[s-1].m;
      if (s < NV) begin
        if (vt[s].d) begin
          if (idx_m == CTR_IDX_NONE) idx_m = cnt_m;
          eq_m = 1'b0;
        end
        cnt_m = cnt_m + 16'd1;
        e.equiv = eq_m; e.mis = vt[s].d; e.cnt = cnt_m; e.idx = idx_m;
        sbq.push_back(e);
        drive(1'b1, vt[s].a, 1'b1, vt[s].b, 1'b0);
      end else begin
        drive(1'b0, '0, 1'b0, '0, 1'b0);
      end
    end
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    idle(1);
    check("tbl done",  32'(done),  32'd1);
    check("tbl idx",   32'(idx),   32'd4);
    check("tbl count", 32'(cnt),   32'd8);
    check("tbl equiv", 32'(equiv), 32'd0);

    // Run 2 lags by 3 cycles; pair 3 differs in bit 0.
    do_reset();
    for (int s = 0; s < 10; s++) begin
      v1 = W'(s + 1);
      v2 = W'(s - 2);
      if (s - 3 == 3) v2[0] = ~v2[0];
      drive(s < 6, v1, (s >= 3) && (s < 9), v2, 1'b0);
      if (s == 6) begin
        check("lag equiv before", 32'(equiv), 32'd1);
        check("lag count before", 32'(cnt),   32'd3);
      end
      if (s == 7) begin
        check("lag equiv after", 32'(equiv), 32'd0);
        check("lag idx",         32'(idx),   32'd3);
        check("lag mismatch",    32'(mis),   32'd1);
      end
    end
    idle(1);
    check("lag pulses", 32'(mis_pulses), 32'd1);
    check("lag count",  32'(cnt),        32'd6);

    // Overflow: run 1 retires 9 records, run 2 idle.
    do_reset();
    for (int i = 0; i < 9; i++) drive(1'b1, W'(i + 10), 1'b0, '0, 1'b0);
    check("ovf flag",     32'(ovf),   32'd1);
    check("ovf equiv",    32'(equiv), 32'd0);
    check("ovf mismatch", 32'(mis),   32'd1);
    check("ovf idx",      32'(idx),   32'(CTR_IDX_NONE));
    for (int i = 0; i < 8; i++) drive(1'b0, '0, 1'b1, W'(i + 10), 1'b0);
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    idle(1);
    check("ovf held count", 32'(cnt),  32'd8);
    check("ovf held idx",   32'(idx),  32'(CTR_IDX_NONE));
    check("ovf done",       32'(done), 32'd1);

    // Push into a full queue that pops the same cycle is not an overflow.
    do_reset();
    for (int s = 0; s < 20; s++) begin
      drive((s < 8) || ((s >= 9) && (s <= 12)), W'((s < 8) ? s : s - 1),
            s >= 8, W'(s - 8), 1'b0);
    end
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    idle(1);
    check("fullpop overflow", 32'(ovf),   32'd0);
    check("fullpop equiv",    32'(equiv), 32'd1);
    check("fullpop count",    32'(cnt),   32'd12);
    check("fullpop done",     32'(done),  32'd1);

    // Retire-count divergence: 4 vs 3, then drain; DONE ignores everything.
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, W'(i + 1), i < 3, W'(i + 1), 1'b0);
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    idle(1);
    check("div done",     32'(done),  32'd1);
    check("div idx",      32'(idx),   32'd3);
    check("div count",    32'(cnt),   32'd3);
    check("div equiv",    32'(equiv), 32'd0);
    check("div mismatch", 32'(mis),   32'd1);
    for (int i = 0; i < 3; i++) drive(1'b1, W'(i + 40), 1'b1, W'(i + 80), 1'b1);
    idle(1);
    check("done hold count",    32'(cnt),  32'd3);
    check("done hold idx",      32'(idx),  32'd3);
    check("done hold done",     32'(done), 32'd1);
    check("done hold mismatch", 32'(mis),  32'd0);

    // Reset during DRAIN with both queues occupied.
    do_reset();
    for (int s = 0; s < 8; s++) drive(1'b1, W'(50 + s), 1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b1, W'(50), 1'b0);
    drive(1'b0, '0, 1'b1, W'(51), 1'b1);
    check("mid-drain done", 32'(done), 32'd0);
    check("mid-drain count", 32'(cnt), 32'd1);
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    rst = 1'b0;
    check_reset_vals("drain reset");
    drive(1'b1, W'(7), 1'b1, W'(7), 1'b0);
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    idle(1);
    check("post-reset done",  32'(done),  32'd1);
    check("post-reset count", 32'(cnt),   32'd1);
    check("post-reset equiv", 32'(equiv), 32'd1);
    check("post-reset idx",   32'(idx),   32'(CTR_IDX_NONE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ctr_obs_sync.md
# ctr_obs_sync

Relational contract checker for two lock-stepped simulations of the same core whose retirements need not be cycle-aligned. Each run pushes one packed contract observation per retired instruction into its own queue. The block compares queued observations pairwise in program order under a runtime field mask, and keeps a sticky equivalence verdict. It sits between the two per-run observation builders and the formal top that asserts `ctr_equiv_o`.

## Interface
- `OBS_W`, 128: width of one packed observation record.
- `DEPTH`, 8: per-run queue depth, in records; power of two, ≥ 2.
- `CNT_W`, 16: width of the pair counter and the mismatch index.

Ports:
- `clk_i`  in  1  single clock; all state updates on posedge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `retire_1_i`  in  1  run 1 retires one instruction this cycle.
- `obs_1_i`  in  OBS_W  run 1 observation; valid when `retire_1_i` is high.
- `retire_2_i`  in  1  run 2 retire strobe.
- `obs_2_i`  in  OBS_W  run 2 observation.
- `obs_mask_i`  in  OBS_W  1 = bit participates in comparison; sampled in the compare cycle.
- `drain_i`  in  1  end-of-trace request; one-cycle pulse.
- `ctr_equiv_o`  out  1  sticky verdict; reset 1.
- `mismatch_o`  out  1  one-cycle pulse on any detected violation; reset 0.
- `mismatch_idx_o`  out  CNT_W  pair index of the first violation; reset all-ones, meaning none.
- `cmp_count_o`  out  CNT_W  pairs compared so far, saturating; reset 0.
- `overflow_o`  out  1  sticky; a queue dropped a record; reset 0.
- `done_o`  out  1  drain finished; reset 0.

## Operation
- Two identical queues, Q1 and Q2. A retire strobe pushes the corresponding observation.
- Compare condition: Q1 and Q2 are both non-empty and the state is not DONE. When it holds:
  - Pop both heads.
  - diff = ((head1 ^ head2) & obs_mask_i) != 0.
  - cmp_count increments, saturating at 2^CNT_W−1.
- diff = 1 has three effects:
  - `ctr_equiv_o` ← 0.
  - `mismatch_o` pulses.
  - `mismatch_idx_o` ← cmp_count value before the increment, only if it is still all-ones (first violation only).
- Overflow: a push into a full queue with no pop that cycle drops the record. This sets `overflow_o`=1 and `ctr_equiv_o`=0 and pulses `mismatch_o`. It does not change `mismatch_idx_o`.
- Push into a full queue while the same queue pops in that cycle is legal, with no overflow.
- Simultaneous push and pop on an empty queue is not possible, because pop requires non-empty. The record is pushed normally.
- FSM:
  - RUN: default state; `drain_i` → DRAIN.
  - DRAIN: retires are still accepted and comparisons continue. Once the compare condition is false, the block checks occupancy:
    - Both queues empty: verdict unchanged.
    - Otherwise (retire-count divergence): `ctr_equiv_o`←0, `mismatch_o` pulses, and `mismatch_idx_o` ← cmp_count if still unset.
    - In both cases → DONE.
  - DONE: `done_o`=1. Retires, `drain_i` and comparisons are ignored and all outputs hold. Only `rst_i` exits.
- `drain_i` in DRAIN or DONE is ignored.
- `ctr_equiv_o` never returns to 1 except through reset.

## Timing
- A retire at edge t is written into its queue at t. It is comparable at t+1 at the earliest.
- Compare result is registered: `ctr_equiv_o`, `mismatch_o`, `mismatch_idx_o` and `cmp_count_o` update at the edge ending the compare cycle. Retire-to-verdict latency is 2 cycles when both runs retire together.
- Drain decision: if `drain_i` arrives at edge t with nothing comparable at t+1, then `done_o`=1 from edge t+2.
- `rst_i` wins over every event in the same cycle. It empties both queues, returns the FSM to RUN and restores all output reset values, including mid-drain.
- Throughput: one pair per cycle. Each queue absorbs a retirement skew of up to DEPTH records.

## Structure
- `ctr_pkg`:
  - FSM enum `ctr_sync_state_e` {RUN, DRAIN, DONE}.
  - Default parameter constants.
  - `CTR_IDX_NONE` (all-ones) constant.
- Sub-module `ctr_obs_fifo`: parametrised synchronous FIFO, instantiated twice.
  - Parameters: width, depth.
  - Ports: push, pop, full, empty, head.
  - Pointers are log2(DEPTH)+1 bits with a wrap bit.
- The top holds the FSM, masked comparator, counters and sticky flags.

## Test plan
- Both runs retire identical records 0x1..0x5 on the same cycles, mask all-ones, then drain → `ctr_equiv_o`=1, `cmp_count_o`=5, `done_o`=1, `mismatch_idx_o`=all-ones.
- Run 2 lags run 1 by 3 cycles, with 6 equal records; pair 3 differs in bit 0 → `ctr_equiv_o` drops 2 cycles after run 2's 4th retire, `mismatch_idx_o`=3, one `mismatch_o` pulse.
- Records differ only in bit 100 with mask bit 100 = 0 → no mismatch, `ctr_equiv_o`=1; then flip mask bit 100 to 1 for a later differing pair → verdict 0.
- DEPTH=8: run 1 retires 9 records while run 2 is idle → `overflow_o`=1, `ctr_equiv_o`=0, Q1 holds 8 records.
- Run 1 retires 4 records, run 2 retires 3, then drain → 3 pairs compared, then count-mismatch violation: `mismatch_idx_o`=3, `done_o`=1.
- `rst_i` asserted in DRAIN with both queues non-empty → next cycle all outputs at reset values, queues empty, state RUN.
